// File: rtl/fgio_preact_mac.sv
// fgio_preact_mac
//
// Sequential multiply-accumulate stage that builds the gate pre-activation
// vector for fgio. For each row r it accumulates W[r][k]*xh[k] over all
// IN_LEN operands and then adds the row bias:
//     preact[r] = (sum_k W[r][k]*xh[k]) >>> FRAC_BITS + bias[r]
// The shift is arithmetic with floor rounding. Weights and biases arrive
// over a valid/ready stream, one row at a time: IN_LEN weights and then
// one bias word.
//
// Ports:
//   clk      - system clock
//   rst_n    - synchronous active-low reset
//   start    - begin one full pass; only looked at while idle
//   xh_in    - operand vector, captured when start is accepted
//   w_valid  - w_data carries a stream word
//   w_ready  - block takes w_data this cycle (high only while running)
//   w_data   - weight/bias stream word
//   preact   - result registers, driven straight into fgio_in
//   busy     - a pass is in progress
//   done     - one-cycle pulse after the last row has been written
//
// Optional feature, macro FGIO_PREACT_SAT_EN:
//   defined   - each result saturates to the signed 32-bit range
//   undefined - each result wraps to its low 32 bits
module fgio_preact_mac #(
    parameter int IN_LEN    = 200,
    parameter int OUT_LEN   = 400,
    parameter int FRAC_BITS = 16,
    parameter int ACC_W     = 72
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [31:0] xh_in [0:IN_LEN-1],
    input  logic               w_valid,
    output logic               w_ready,
    input  logic signed [31:0] w_data,
    output logic signed [31:0] preact [0:OUT_LEN-1],
    output logic               busy,
    output logic               done
);

    // col_cnt has to reach IN_LEN (the bias slot), so it needs one more
    // code than the operand index.
    localparam int CW = $clog2(IN_LEN + 1);
    localparam int XW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int RW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic signed [31:0]       xh_q [0:IN_LEN-1];
    logic signed [31:0]       xh_d [0:IN_LEN-1];
    logic signed [31:0]       preact_q [0:OUT_LEN-1];
    logic signed [31:0]       preact_d [0:OUT_LEN-1];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]            col_cnt_q, col_cnt_d;
    logic [RW-1:0]            row_cnt_q, row_cnt_d;
    logic                     w_ready_q, busy_q, done_q;

    logic signed [31:0]       xh_sel;
    logic signed [63:0]       prod;
`ifdef FGIO_PREACT_SAT_EN
    logic signed [ACC_W-1:0]  row_sum;
    logic                     row_fits;
`endif

    // Next-state logic. A beat is only taken when the stream offers data
    // while we are ready; with w_valid low nothing moves.
    always_comb begin
        state_d   = state_q;
        xh_d      = xh_q;
        preact_d  = preact_q;
        acc_d     = acc_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        xh_sel    = xh_q[col_cnt_q[XW-1:0]];
        prod      = '0;
`ifdef FGIO_PREACT_SAT_EN
        row_sum   = '0;
        row_fits  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    xh_d      = xh_in;
                    acc_d     = '0;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (w_valid && w_ready_q) begin
                    if (col_cnt_q != CW'(IN_LEN)) begin
                        // Full 64-bit signed product, sign-extended into the accumulator.
                        prod      = $signed({{32{w_data[31]}}, w_data}) *
                                    $signed({{32{xh_sel[31]}}, xh_sel});
                        acc_d     = acc_q + $signed({{(ACC_W-64){prod[63]}}, prod});
                        col_cnt_d = col_cnt_q + CW'(1);
                    end else begin
`ifdef FGIO_PREACT_SAT_EN
                        row_sum  = (acc_q >>> FRAC_BITS) +
                                   $signed({{(ACC_W-32){w_data[31]}}, w_data});
                        // Fits in 32 bits when every bit from 31 upward matches the sign.
                        row_fits = (&row_sum[ACC_W-1:31]) || !(|row_sum[ACC_W-1:31]);
                        if (row_fits) begin
                            preact_d[row_cnt_q] = row_sum[31:0];
                        end else if (row_sum[ACC_W-1]) begin
                            preact_d[row_cnt_q] = 32'sh8000_0000;
                        end else begin
                            preact_d[row_cnt_q] = 32'sh7FFF_FFFF;
                        end
`else
                        // The low 32 bits of (acc >>> FRAC_BITS) are just a slice of acc.
                        preact_d[row_cnt_q] = acc_q[FRAC_BITS +: 32] + w_data;
`endif
                        acc_d     = '0;
                        col_cnt_d = '0;
                        if (row_cnt_q == RW'(OUT_LEN - 1)) begin
                            state_d   = S_DONE;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + RW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/status outputs. The outputs
    // are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            xh_q      <= '{default: '0};
            preact_q  <= '{default: '0};
            acc_q     <= '0;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            w_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xh_q      <= xh_d;
            preact_q  <= preact_d;
            acc_q     <= acc_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            w_ready_q <= (state_d == S_RUN);
            busy_q    <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign preact  = preact_q;
    assign w_ready = w_ready_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fgio_preact_mac.sv
// Testbench for fgio_preact_mac, built with a small geometry so full passes
// stay short. A behavioural model computes every row with wide plain
// arithmetic from the words it saw accepted, and a compare process checks
// all outputs each cycle.
module tb_fgio_preact_mac;

    localparam int IN_LEN    = 8;
    localparam int OUT_LEN   = 10;
    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = 72;
    localparam int N         = OUT_LEN * (IN_LEN + 1);

    localparam logic signed [127:0] MAXV = 128'sd2147483647;
    localparam logic signed [127:0] MINV = -(128'sd2147483648);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [31:0] xh_in [0:IN_LEN-1];
    logic               w_valid;
    logic               w_ready;
    logic signed [31:0] w_data;
    logic signed [31:0] preact [0:OUT_LEN-1];
    logic               busy;
    logic               done;

    int  checks     = 0;
    int  failures   = 0;
    int  cyc        = 0;
    int  done_count = 0;
    bit  check_en   = 1'b0;

    logic [31:0] xh_tb  [IN_LEN];
    logic [31:0] stream [N];

    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
    mphase_t     m_phase;
    logic [31:0] m_xh     [IN_LEN];
    logic [31:0] m_preact [OUT_LEN];
    logic [31:0] m_words  [$];
    int          m_row;
    int          m_beats;

    fgio_preact_mac #(
        .IN_LEN   (IN_LEN),
        .OUT_LEN  (OUT_LEN),
        .FRAC_BITS(FRAC_BITS),
        .ACC_W    (ACC_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .xh_in  (xh_in),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_data (w_data),
        .preact (preact),
        .busy   (busy),
        .done   (done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One row of the reference: exact wide dot product, floor shift, bias,
    // then wrap or saturate to 32 bits.
    function automatic logic [31:0] modelRow();
        logic signed [127:0] s;
        logic signed [127:0] a;
        logic signed [127:0] b;
        s = '0;
        for (int k = 0; k < IN_LEN; k++) begin
            a = 128'($signed(m_xh[k]));
            b = 128'($signed(m_words[k]));
            s = s + a * b;
        end
        s = s >>> FRAC_BITS;
        s = s + 128'($signed(m_words[IN_LEN]));
`ifdef FGIO_PREACT_SAT_EN
        if (s > MAXV) return 32'h7FFF_FFFF;
        if (s < MINV) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // Reference model: tracks the pass at transaction level and collects
    // accepted stream words per row.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_phase = M_IDLE;
            for (int r = 0; r < OUT_LEN; r++) m_preact[r] = '0;
            for (int k = 0; k < IN_LEN; k++) m_xh[k] = '0;
            m_words.delete();
            m_row   = 0;
            m_beats = 0;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if (start) begin
                        m_phase = M_RUN;
                        for (int k = 0; k < IN_LEN; k++) m_xh[k] = xh_in[k];
                        m_words.delete();
                        m_row   = 0;
                        m_beats = 0;
                    end
                end
                M_RUN: begin
                    if (w_valid) begin
                        m_words.push_back(w_data);
                        m_beats++;
                        if (m_words.size() == IN_LEN + 1) begin
                            m_preact[m_row] = modelRow();
                            m_row++;
                            m_words.delete();
                        end
                        if (m_beats == N) m_phase = M_DONE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("w_ready", {31'b0, w_ready}, {31'b0, m_phase == M_RUN});
            checkOutput("busy",    {31'b0, busy},    {31'b0, m_phase == M_RUN});
            checkOutput("done",    {31'b0, done},    {31'b0, m_phase == M_DONE});
            for (int r = 0; r < OUT_LEN; r++)
                checkOutput($sformatf("preact[%0d]", r), preact[r], m_preact[r]);
            if (done === 1'b1) done_count++;
        end
    end

    // Runs one pass. vmode: 0 valid always, 1 valid toggling, 2 random.
    // restart_row/reset_row < 0 disable the start pulse / mid-pass reset.
    task automatic applyStimulus(input int vmode, input bit jitter,
                                 input int restart_row, input int reset_row);
        int ptr = 0;
        int start_cyc;
        int diff;
        int budget;
        int dbefore;
        bit finished = 1'b0;
        dbefore = done_count;
        @(negedge clk);
        for (int k = 0; k < IN_LEN; k++) xh_in[k] = xh_tb[k];
        start     = 1'b1;
        w_valid   = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
        budget = 3 * N + 40;
        while (!finished) begin
            diff = cyc - start_cyc;
            if (done === 1'b1) begin
                finished = 1'b1;
                case (vmode)
                    0:       checkOutput("latency_full", diff, N + 1);
                    1:       checkOutput("latency_toggle", diff, 2 * N + 1);
                    default: checkOutput("latency_min", {31'b0, diff >= N + 1}, 1);
                endcase
            end else if (budget == 0) begin
                checkOutput("pass_timeout", 0, 1);
                finished = 1'b1;
            end else begin
                budget--;
                case (vmode)
                    0:       w_valid = 1'b1;
                    1:       w_valid = (diff % 2 == 0);
                    default: w_valid = 1'($urandom_range(0, 1));
                endcase
                w_data = (ptr < N) ? stream[ptr] : 32'($urandom);
                start  = (restart_row >= 0) && (ptr == restart_row * (IN_LEN + 1));
                if (jitter)
                    for (int k = 0; k < IN_LEN; k++) xh_in[k] = 32'($urandom);
                if (reset_row >= 0 && ptr == reset_row * (IN_LEN + 1)) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    checkOutput("midreset_busy", {31'b0, busy}, 0);
                    checkOutput("midreset_preact0", preact[0], 0);
                    rst_n    = 1'b1;
                    start    = 1'b0;
                    finished = 1'b1;
                end else begin
                    if (w_valid && w_ready) ptr++;
                    @(negedge clk);
                end
            end
        end
        w_valid = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", done_count - dbefore, (reset_row >= 0) ? 0 : 1);
    endtask

    // Identity weights: row r picks operand r mod IN_LEN at 1.0, bias 0.5.
    task automatic loadIdentity();
        for (int k = 0; k < IN_LEN; k++) xh_tb[k] = 32'(k) << 16;
        for (int r = 0; r < OUT_LEN; r++) begin
            for (int k = 0; k < IN_LEN; k++)
                stream[r * (IN_LEN + 1) + k] = (k == r % IN_LEN) ? 32'h0001_0000 : 32'h0;
            stream[r * (IN_LEN + 1) + IN_LEN] = 32'h0000_8000;
        end
    endtask

    task automatic checkIdentity(input string tag);
        for (int r = 0; r < OUT_LEN; r++)
            checkOutput($sformatf("%s_row%0d", tag, r), preact[r],
                        (32'(r % IN_LEN) << 16) + 32'h0000_8000);
    endtask

    // Test sequence
    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        w_valid = 1'b1;
        w_data  = '1;
        for (int k = 0; k < IN_LEN; k++) xh_in[k] = '0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_w_ready", {31'b0, w_ready}, 0);
        checkOutput("reset_busy", {31'b0, busy}, 0);
        checkOutput("reset_done", {31'b0, done}, 0);
        checkOutput("reset_preact_last", preact[OUT_LEN-1], 0);
        rst_n   = 1'b1;
        w_valid = 1'b0;

        $display("[TB] identity pass, valid held high");
        loadIdentity();
        applyStimulus(0, 1'b0, -1, -1);
        checkIdentity("ident");

        $display("[TB] negative floor rounding");
        for (int k = 0; k < IN_LEN; k++) xh_tb[k] = 32'($urandom);
        xh_tb[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) stream[i] = 32'($urandom);
        for (int k = 0; k <= IN_LEN; k++) stream[k] = (k == 0) ? 32'h1 : 32'h0;
        applyStimulus(0, 1'b0, -1, -1);
        checkOutput("neg_floor_row0", preact[0], 32'hFFFF_FFFF);

        $display("[TB] identity pass, valid toggling");
        loadIdentity();
        applyStimulus(1, 1'b0, -1, -1);
        checkIdentity("bp");

        $display("[TB] overflow pass");
        for (int k = 0; k < IN_LEN; k++) xh_tb[k] = 32'h7FFF_FFFF;
        for (int r = 0; r < OUT_LEN; r++) begin
            for (int k = 0; k < IN_LEN; k++) stream[r * (IN_LEN + 1) + k] = 32'h7FFF_FFFF;
            stream[r * (IN_LEN + 1) + IN_LEN] = 32'h0;
        end
        applyStimulus(2, 1'b0, -1, -1);
        for (int r = 0; r < OUT_LEN; r++)
`ifdef FGIO_PREACT_SAT_EN
            checkOutput($sformatf("ovf_row%0d", r), preact[r], 32'h7FFF_FFFF);
`else
            checkOutput($sformatf("ovf_row%0d", r), preact[r], 32'hFFF8_0000);
`endif

        $display("[TB] random pass with xh_in changing after the latch");
        for (int k = 0; k < IN_LEN; k++) xh_tb[k] = 32'($urandom);
        for (int i = 0; i < N; i++) stream[i] = 32'($urandom);
        applyStimulus(2, 1'b1, -1, -1);

        $display("[TB] start during run, then reset mid-pass");
        for (int k = 0; k < IN_LEN; k++) xh_tb[k] = 32'($urandom);
        for (int i = 0; i < N; i++) stream[i] = 32'($urandom);
        applyStimulus(0, 1'b0, 2, 4);
        checkOutput("after_reset_preact_last", preact[OUT_LEN-1], 0);
        checkOutput("after_reset_w_ready", {31'b0, w_ready}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fgio_preact_mac.md
Name: fgio_preact_mac

Overview:
- Sequential multiply-accumulate stage that produces the 400-word gate pre-activation vector consumed by fgio as fgio_in.
- Computes preact[r] = (sum over k of W[r][k]*xh[k]) >>> FRAC_BITS + bias[r], one row at a time, for r = 0..OUT_LEN-1.
- xh is the concatenation of x_t and h_(t-1).
- Weights and biases stream in over a valid/ready channel from weight memory. The result vector is held in registers and drives fgio directly.

Parameters:
- IN_LEN, 200: length of the xh operand vector (x_t 100 + h_(t-1) 100).
- OUT_LEN, 400: number of pre-activation rows (f, g, i, o; 100 each).
- FRAC_BITS, 16: fixed-point fraction bits of all 32-bit signed operands.
- ACC_W, 72: accumulator width; must be at least 64 + ceil(log2(IN_LEN)).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin one full pass; sampled only in IDLE.
- xh_in[0:IN_LEN-1]  input  32 signed each  operand vector; latched on accepted start.
- w_valid  input  1  w_data is valid.
- w_ready  output  1  block accepts w_data this cycle.
- w_data  input  32 signed  stream word: per row, IN_LEN weights (k = 0..IN_LEN-1), then 1 bias word.
- preact[0:OUT_LEN-1]  output  32 signed each  pre-activation result registers (to fgio_in).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse when all OUT_LEN rows are written.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, evaluated on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - w_ready = 0, busy = 0, done = 0.
  - All preact words = 0; accumulator, row_cnt and col_cnt = 0.
  - The xh latch is cleared to 0.
- States:
  - IDLE -> RUN when start = 1. xh_in is latched, row_cnt = col_cnt = 0, acc = 0.
  - RUN -> DONE when the bias beat of row OUT_LEN-1 is accepted.
  - DONE -> IDLE unconditionally after 1 cycle. done = 1 only in DONE.
- w_ready = 1 exactly in RUN. A beat is accepted when w_valid && w_ready. When w_valid = 0, the block stalls with no state change.
- Weight beat (col_cnt < IN_LEN):
  - acc += sign-extended 64-bit product w_data * xh[col_cnt].
  - col_cnt++.
- Bias beat (col_cnt == IN_LEN):
  - preact[row_cnt] <= trunc32((acc >>> FRAC_BITS) + sign-extended w_data).
  - acc <= 0, col_cnt <= 0, row_cnt++.
  - The shift is arithmetic, with floor rounding (no round-to-nearest).
- preact words not yet rewritten in a pass keep their previous-pass values. preact is stable in IDLE.
- Latency: with w_valid held high, done asserts exactly OUT_LEN*(IN_LEN+1) + 1 cycles after the start cycle. Defaults: 80401 cycles.
- start while busy or in DONE: ignored. xh_in changes after the latch have no effect.
- Reset mid-pass: on the next edge, everything returns to reset values and the pass is abandoned. No done pulse.
- The accumulator never wraps for legal ACC_W. Final narrowing to 32 bits follows the optional-feature rule.

Optional Feature:
- Macro: FGIO_PREACT_SAT_EN.
- Defined: the 32-bit result saturates. Values above 2^31-1 become 0x7FFFFFFF; values below -2^31 become 0x80000000.
- Undefined: two's-complement truncation to the low 32 bits (wrap).
- All other behaviour is identical either way.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n = 0 for 2 cycles with w_valid = 1.
  - Response: all preact = 0, w_ready = 0, busy = 0, done never pulses.
- Identity pass:
  - Stimulus: xh[k] = k<<16. Row r weights are 1.0 (0x00010000) at k = r mod 200, else 0. Bias = 0x00008000. w_valid held high.
  - Response: preact[r] = ((r mod 200)<<16) + 0x8000. done pulses exactly at start+80401.
- Backpressure:
  - Stimulus: same vectors with w_valid toggled 1,0,1,0.
  - Response: identical preact values. done at start+160801 or later, one pulse only.
- Negative floor rounding:
  - Stimulus: xh[0] = -1 (0xFFFFFFFF), row 0 weight[0] = 1, all other weights 0, bias 0.
  - Response: preact[0] = 0xFFFFFFFF (floor of -2^-16 gives -1 LSB).
- Overflow:
  - Stimulus: all xh = 0x7FFFFFFF, all weights = 0x7FFFFFFF, bias 0.
  - Response with FGIO_PREACT_SAT_EN: preact = 0x7FFFFFFF.
  - Response without it: the low 32 bits of the exact shifted sum.
- Start ignored and mid-pass reset:
  - Stimulus: pulse start again during RUN at row 5.
  - Response: no restart; row_cnt continues.
  - Stimulus: then rst_n = 0 at row 10.
  - Response: IDLE next cycle, preact all 0, no done pulse.
